// File: rtl/hilo_div_seq_if.sv
// Request/response bundle between the E-stage controller and the HI/LO divide sequencer.
// The master drives the divide request; the slave (the divider) returns stall and the HI/LO write.
interface hilo_div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_div;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             hilo_we;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, signed_div, a, b, flush,
        input  stall, busy, hilo_we, hi_out, lo_out
    );

    modport slave (
        input  start, signed_div, a, b, flush,
        output stall, busy, hilo_we, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_div_seq.sv
// Radix-2 restoring DIV/DIVU sequencer: stalls E while iterating, then pulses a HI/LO write.
// Define HILO_DIV_ZERO_FAST_EN to skip iteration when the divisor is zero.
module hilo_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    hilo_div_seq_if.slave  bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CntW-1:0]  r_count;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic             w_accept;
    logic             w_abort;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_a_neg  = bus.signed_div & bus.a[WIDTH-1];
    assign w_b_neg  = bus.signed_div & bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;
    assign w_b_zero = (bus.b == '0);
    assign w_accept = (r_state == StIdle) & bus.start & ~bus.flush;
    // A start that drops mid-iteration means the instruction was killed upstream.
    assign w_abort  = bus.flush | ~bus.start;

    // The extra top bit is the borrow: set means the shifted remainder is below the divisor.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_div};
    assign w_fit     = ~w_diff[WIDTH];
    assign w_rem_nxt = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_count <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_div   <= w_b_mag;
                        r_count <= '0;
                        // Zero divisor: unsigned all-ones quotient, remainder restores to a.
                        r_qneg  <= ~w_b_zero & (w_a_neg ^ w_b_neg);
                        r_rneg  <= w_a_neg;
`ifdef HILO_DIV_ZERO_FAST_EN
                        if (w_b_zero) begin
                            r_hi    <= bus.a;
                            r_lo    <= '1;
                            r_state <= StDone;
                        end else begin
                            r_state <= StBusy;
                        end
`else
                        r_state <= StBusy;
`endif
                    end
                end
                StBusy: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                    end else begin
                        r_rem   <= w_rem_nxt;
                        r_quo   <= w_quo_nxt;
                        r_count <= r_count + 1'b1;
                        if (r_count == LastCnt) begin
                            r_lo    <= r_qneg ? -w_quo_nxt : w_quo_nxt;
                            r_hi    <= r_rneg ? -w_rem_nxt : w_rem_nxt;
                            r_state <= StDone;
                        end
                    end
                end
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy    = (r_state != StIdle);
    assign bus.stall   = w_accept | (r_state == StBusy);
    assign bus.hilo_we = (r_state == StDone) & ~bus.flush;
    assign bus.hi_out  = r_hi;
    assign bus.lo_out  = r_lo;

endmodule

// File: tb/tb_hilo_div_seq.sv
// Directed bench for hilo_div_seq: result values, latency, stall window, flush, reset, back-to-back.
module tb_hilo_div_seq;
    localparam int unsigned WIDTH = 32;
    localparam int NormLat = WIDTH + 1;
`ifdef HILO_DIV_ZERO_FAST_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = WIDTH + 1;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    hilo_div_seq_if #(.WIDTH(WIDTH)) bus ();

    hilo_div_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Raises start at the next negedge and holds it until the write strobe; returns #1 into DONE.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int exp_lat);
        int cyc;
        int stall_cnt;
        bit seen;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.signed_div = sgn;
        bus.a          = av;
        bus.b          = bv;
        cyc       = 0;
        stall_cnt = 0;
        seen      = 1'b0;
        while (!seen && cyc < 100) begin
            #1;
            if (bus.hilo_we) begin
                seen = 1'b1;
            end else begin
                if (bus.stall) stall_cnt++;
                @(negedge clk);
                cyc++;
            end
        end
        check_eq({tag, " latency"}, cyc, exp_lat);
        check_eq({tag, " stall cycles"}, stall_cnt, exp_lat);
        if (seen) begin
            check_eq({tag, " stall in done"}, {31'd0, bus.stall}, 32'd0);
            check_eq({tag, " lo"}, bus.lo_out, exp_lo);
            check_eq({tag, " hi"}, bus.hi_out, exp_hi);
        end
        bus.start = 1'b0;
    endtask

    task automatic count_we(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (bus.hilo_we) hits++;
        end
        check_eq({tag, " no hilo_we"}, hits, 0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.a          = '0;
        bus.b          = '0;
        bus.flush      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset busy", {31'd0, bus.busy}, 32'd0);
        check_eq("reset stall", {31'd0, bus.stall}, 32'd0);
        check_eq("reset we", {31'd0, bus.hilo_we}, 32'd0);
        check_eq("reset hi", bus.hi_out, 32'd0);
        check_eq("reset lo", bus.lo_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, NormLat);
        @(negedge clk);
        #1;
        check_eq("idle after done we", {31'd0, bus.hilo_we}, 32'd0);
        check_eq("idle lo held", bus.lo_out, 32'd14);
        check_eq("idle hi held", bus.hi_out, 32'd2);

        do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, NormLat);
        do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, NormLat);
        do_div("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE,
               NormLat);
        do_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, NormLat);
        do_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, NormLat);
        do_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZeroLat);
        do_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, ZeroLat);

        // Flush on the 10th busy cycle.
        @(negedge clk);
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.a          = 32'd1000;
        bus.b          = 32'd3;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check_eq("flush busy before", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        #1;
        check_eq("flush busy after", {31'd0, bus.busy}, 32'd0);
        count_we("flush", 40);
        do_div("divu 9/3 after flush", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, NormLat);

        // Start dropping mid-iteration aborts the same way.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd77;
        bus.b     = 32'd5;
        repeat (5) @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        check_eq("start drop busy", {31'd0, bus.busy}, 32'd0);
        count_we("start drop", 40);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        repeat (20) @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_eq("midrst busy", {31'd0, bus.busy}, 32'd0);
        check_eq("midrst we", {31'd0, bus.hilo_we}, 32'd0);
        check_eq("midrst hi", bus.hi_out, 32'd0);
        check_eq("midrst lo", bus.lo_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_we("midrst", 40);

        do_div("b2b first 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, NormLat);
        do_div("b2b second 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, NormLat);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
